cpu_out_port: RTL and testbench

- Receiving end of the CPU's 8-bit output bus (cpu_out).
- Captures every CPU output write into a small FIFO and presents it to a downstream consumer over a valid/ready stream, such as a display, a UART transmitter or a bench scoreboard.
- Decouples CPU execution from a slow sink.
- Counts and flags writes lost to a full buffer.

---
 rtl/cpu_io_pkg.sv | 11 +
 rtl/sync_fifo.sv | 46 ++++
 rtl/cpu_out_port.sv | 71 +++++++
 tb/tb_cpu_out_port.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_io_pkg.sv
// Shared types and constants for the CPU output-bus receiver.
// Imported by the FIFO and by the port wrapper.
package cpu_io_pkg;

    localparam int DATA_W = 8;

    typedef logic [DATA_W-1:0] io_byte_t;

    localparam logic [7:0] DROP_CNT_MAX = 8'hFF;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular buffer. The pointers carry one extra MSB so that
// full and empty are both distinguishable while the index bits are equal.
module sync_fifo
    import cpu_io_pkg::*;
#(
    parameter int DATA_W = cpu_io_pkg::DATA_W,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int PTR_W = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [PTR_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Storage has no reset; stale contents are never visible while empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count   = wr_ptr - rd_ptr;

endmodule

// File: rtl/cpu_out_port.sv
// Receiving end of the CPU output bus: buffers every write in a FIFO,
// streams it out over valid/ready, and tracks writes lost to a full buffer.
module cpu_out_port
    import cpu_io_pkg::*;
#(
    parameter int DATA_W = cpu_io_pkg::DATA_W,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              out_we,
    input  logic [DATA_W-1:0] out_data,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              full,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic [7:0]        drop_cnt,
    input  logic              clr_ovf
);

    localparam int PTR_W = $clog2(DEPTH) + 1;

    logic             empty;
    logic             rd_acc;
    logic             wr_acc;
    logic             drop;
    logic [PTR_W-1:0] fifo_count;

    assign m_valid = ~empty;
    assign rd_acc  = m_valid & m_ready;
    // A same-cycle read frees the slot, so a draining full FIFO still accepts.
    assign wr_acc  = out_we & (~full | rd_acc);
    assign drop    = out_we & ~wr_acc;
    assign count   = CNT_W'(fifo_count);

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .reset   (reset),
        .wr_en   (wr_acc),
        .wr_data (out_data),
        .rd_en   (rd_acc),
        .rd_data (m_data),
        .empty   (empty),
        .full    (full),
        .count   (fifo_count)
    );

    // A drop coinciding with a clear wins: the counter restarts at one.
    always_ff @(posedge CLK) begin
        if (reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_ovf)
                drop_cnt <= 8'd1;
            else if (drop_cnt != DROP_CNT_MAX)
                drop_cnt <= drop_cnt + 8'd1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_cpu_out_port.sv
// Directed plus randomized bench for cpu_out_port, checked against a
// queue-based reference model of the buffered output port.
module tb_cpu_out_port;
    import cpu_io_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             CLK = 1'b0;
    logic             reset = 1'b1;
    logic             out_we = 1'b0;
    io_byte_t         out_data = '0;
    logic             m_valid;
    io_byte_t         m_data;
    logic             m_ready = 1'b0;
    logic             full;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic [7:0]       drop_cnt;
    logic             clr_ovf = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    io_byte_t q[$];
    bit       m_ovf = 1'b0;
    int       m_dcnt = 0;

    always #5 CLK = ~CLK;

    cpu_out_port #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .CLK      (CLK),
        .reset    (reset),
        .out_we   (out_we),
        .out_data (out_data),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .drop_cnt (drop_cnt),
        .clr_ovf  (clr_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("m_valid", 32'(m_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("m_data", 32'(m_data), 32'(q[0]));
        chk("count", 32'(count), 32'(q.size()));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_dcnt));
    endtask

    // Apply one cycle of inputs, advance the model by the same cycle, then compare.
    task automatic step(input logic we, input io_byte_t d, input logic rdy,
                        input logic clr, input logic rst);
        bit rd, acc, drop;
        out_we   = we;
        out_data = d;
        m_ready  = rdy;
        clr_ovf  = clr;
        reset    = rst;
        rd   = (q.size() != 0) && rdy;
        acc  = we && ((q.size() < DEPTH) || rd);
        drop = we && !acc;
        @(posedge CLK);
        #1;
        if (rst) begin
            q.delete();
            m_ovf  = 1'b0;
            m_dcnt = 0;
        end else begin
            if (rd) void'(q.pop_front());
            if (acc) q.push_back(d);
            if (drop) begin
                m_ovf  = 1'b1;
                m_dcnt = clr ? 1 : ((m_dcnt == 255) ? 255 : m_dcnt + 1);
            end else if (clr) begin
                m_ovf  = 1'b0;
                m_dcnt = 0;
            end
        end
        check_model();
    endtask

    task automatic do_reset();
        step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic fill_ramp();
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);

        // 1. Basic pass
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        chk("basic_data", 32'(m_data), 32'hA5);
        chk("basic_count", 32'(count), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("basic_empty", 32'(m_valid), 32'd0);

        // 2. Fill and order
        fill_ramp();
        chk("fill_full", 32'(full), 32'd1);
        for (int i = 1; i <= DEPTH; i++) begin
            chk("order_data", 32'(m_data), 32'(i));
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        chk("drain_empty", 32'(m_valid), 32'd0);

        // 3. Drop and sticky
        fill_ramp();
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hEF, 1'b0, 1'b0, 1'b0);
        chk("drop_cnt2", 32'(drop_cnt), 32'd2);
        chk("drop_count8", 32'(count), 32'd8);
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("sticky_ovf", 32'(overflow), 32'd1);

        // 4. Full with simultaneous read and write
        do_reset();
        fill_ramp();
        step(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
        chk("rw_count", 32'(count), 32'd8);
        chk("rw_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("rw_last", 32'(m_data), 32'h99);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // 5. Clear versus drop collision
        do_reset();
        fill_ramp();
        for (int i = 0; i < 5; i++) step(1'b1, 8'hD0, 1'b0, 1'b0, 1'b0);
        chk("pre_clr_cnt", 32'(drop_cnt), 32'd5);
        step(1'b1, 8'hD1, 1'b0, 1'b1, 1'b0);
        chk("coll_ovf", 32'(overflow), 32'd1);
        chk("coll_cnt", 32'(drop_cnt), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_cnt", 32'(drop_cnt), 32'd0);

        // Drop counter saturation
        for (int i = 0; i < 260; i++) step(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
        chk("sat_cnt", 32'(drop_cnt), 32'hFF);

        // 6. Pointer wrap, then mid-operation reset
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
        chk("pre_rst_cnt", 32'(count), 32'd3);
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
        chk("mid_rst_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        step(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
        chk("after_rst_data", 32'(m_data), 32'h42);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("after_rst_alone", 32'(m_valid), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 40) == 0, $urandom_range(0, 300) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
